// File: rtl/radar_scan_gen.sv
// Radar timing generator: ACP/ARP azimuth pulse train, master trigger and
// azimuth word, with continuous rotation or bidirectional sector scan.
module radar_scan_gen #(
  parameter int AZ_BITS     = 12,
  parameter int ACP_PERIOD  = 24414,
  parameter int ACP_HIGH    = 12207,
  parameter int TRIG_PERIOD = 50000,
  parameter int TRIG_WIDTH  = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [AZ_BITS-1:0] sec_lo,
  input  logic [AZ_BITS-1:0] sec_hi,
  output logic               acp,
  output logic               arp,
  output logic               trig,
  output logic [AZ_BITS-1:0] azimuth,
  output logic               dir,
  output logic               running
);
  localparam int PW = $clog2(ACP_PERIOD);
  localparam int TW = $clog2(TRIG_PERIOD);
  localparam logic [PW-1:0] PH_LAST = PW'(ACP_PERIOD - 1);
  localparam logic [PW-1:0] PH_HIGH = PW'(ACP_HIGH);
  localparam logic [TW-1:0] T_LAST  = TW'(TRIG_PERIOD - 1);
  localparam logic [TW-1:0] T_HIGH  = TW'(TRIG_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  typedef struct packed {
    logic               mode;
    logic [AZ_BITS-1:0] lo;
    logic [AZ_BITS-1:0] hi;
  } cfg_t;

  state_t             state, state_n;
  cfg_t               cfg, cfg_n;
  logic [PW-1:0]      phase, phase_n;
  logic [TW-1:0]      tphase, tphase_n;
  logic [AZ_BITS-1:0] az_n;
  logic               dir_n, wrap, sect, sect_n, act, acp_n, arp_n, trig_n;

  always_comb begin
    state_n  = state;
    cfg_n    = cfg;
    phase_n  = phase;
    tphase_n = tphase;
    az_n     = azimuth;
    dir_n    = dir;
    wrap     = (phase == PH_LAST);
    sect     = cfg.mode && (cfg.lo < cfg.hi);
    case (state)
      IDLE: begin
        phase_n  = '0;
        tphase_n = '0;
        if (en) begin
          state_n = RUN;
          cfg_n   = '{mode, sec_lo, sec_hi};
          dir_n   = 1'b1;
          az_n    = (mode && (sec_lo < sec_hi)) ? sec_lo : '0;
        end
      end
      default: begin
        // Stopping only ends at a period boundary so the last ACP is whole.
        if (wrap && !en) begin
          state_n  = IDLE;
          phase_n  = '0;
          tphase_n = '0;
        end else begin
          state_n  = en ? RUN : STOP;
          phase_n  = wrap ? '0 : phase + 1'b1;
          tphase_n = (tphase == T_LAST) ? '0 : tphase + 1'b1;
          if (wrap) begin
            if (!sect) begin
              az_n = azimuth + 1'b1;
            end else if (dir) begin
              if (azimuth >= cfg.hi) begin
                az_n  = cfg.hi - 1'b1;
                dir_n = 1'b0;
              end else begin
                az_n = azimuth + 1'b1;
              end
            end else begin
              if (azimuth <= cfg.lo) begin
                az_n  = cfg.lo + 1'b1;
                dir_n = 1'b1;
              end else begin
                az_n = azimuth - 1'b1;
              end
            end
          end
        end
      end
    endcase
    // Outputs are derived from next-state values so they register in step.
    sect_n = cfg_n.mode && (cfg_n.lo < cfg_n.hi);
    act    = (state_n != IDLE);
    acp_n  = act && (phase_n < PH_HIGH);
    trig_n = act && (tphase_n < T_HIGH);
    arp_n  = acp_n && (sect_n ? ((az_n == cfg_n.lo) || (az_n == cfg_n.hi))
                              : (az_n == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cfg     <= '0;
      phase   <= '0;
      tphase  <= '0;
      azimuth <= '0;
      dir     <= 1'b0;
      acp     <= 1'b0;
      arp     <= 1'b0;
      trig    <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      cfg     <= cfg_n;
      phase   <= phase_n;
      tphase  <= tphase_n;
      azimuth <= az_n;
      dir     <= dir_n;
      acp     <= acp_n;
      arp     <= arp_n;
      trig    <= trig_n;
      running <= act;
    end
  end
endmodule

// File: doc/radar_scan_gen.md
# radar_scan_gen

Parametrised radar timing generator for the sea-clutter simulator. It produces the azimuth pulse train (ACP), the north/reversal marker (ARP), the master trigger (TRIG) and the current azimuth word from a single system clock. Azimuth resolution, ACP period and duty cycle, and trigger PRF and width are set by parameters. It supports continuous rotation and bidirectional sector scan, with clean start and stop control. It is the timing source for the clutter and video blocks downstream.

## Interface
- AZ_BITS, 12, azimuth resolution; 2^AZ_BITS ACPs per revolution
- ACP_PERIOD, 24414, clk cycles per ACP (488.28 us at 50 MHz)
- ACP_HIGH, 12207, clk cycles ACP is high per period; legal range 1..ACP_PERIOD-1
- TRIG_PERIOD, 50000, clk cycles per trigger (1 kHz PRF at 50 MHz)
- TRIG_WIDTH, 50, clk cycles TRIG is high; legal range 1..TRIG_PERIOD-1
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-low reset
- en  input  1  run request; level-sensitive
- mode  input  1  0 = continuous rotation, 1 = sector scan
- sec_lo  input  AZ_BITS  sector lower bound
- sec_hi  input  AZ_BITS  sector upper bound
- acp  output  1  azimuth change pulse
- arp  output  1  azimuth reset / reversal pulse
- trig  output  1  master trigger
- azimuth  output  AZ_BITS  azimuth of the current ACP period
- dir  output  1  1 = increasing azimuth, 0 = decreasing
- running  output  1  high in RUN and STOP states

## Operation
- Internal counters:
  - phase: 0..ACP_PERIOD-1, width $clog2(ACP_PERIOD).
  - tphase: 0..TRIG_PERIOD-1, width $clog2(TRIG_PERIOD).
- All outputs are registered. Reset value of every output is 0, and state resets to IDLE.
- States:
  - IDLE: counters held at 0; acp, arp, trig and running are 0; azimuth and dir hold their last values.
  - IDLE→RUN when en=1. At that edge:
    - mode, sec_lo and sec_hi are latched; they are ignored until the next IDLE→RUN.
    - phase←0 and tphase←0.
    - Start azimuth is 0 with dir=1 for continuous mode, or sec_lo with dir=1 for sector mode.
  - RUN→STOP when en=0. STOP finishes the current ACP period and goes to IDLE at the edge where phase would wrap. No truncated ACP pulse is ever produced.
  - STOP→RUN if en returns to 1 before the wrap. The cycle continues without a phase reset.
- ACP:
  - acp=1 while phase<ACP_HIGH, in RUN or STOP.
  - At phase=ACP_PERIOD-1, phase←0 and azimuth advances on the same edge, so each ACP rising edge carries its new azimuth.
- Continuous mode:
  - azimuth←azimuth+1, modulo 2^AZ_BITS.
  - arp = acp AND azimuth==0.
- Sector mode (latched sec_lo<sec_hi):
  - dir=1: azimuth+1. When the advance would leave sec_hi, azimuth←sec_hi-1 and dir←0.
  - dir=0: azimuth-1. When the advance would leave sec_lo, azimuth←sec_lo+1 and dir←1.
  - The resulting sequence is lo..hi..lo with the endpoints occurring once per reversal.
  - arp = acp AND (azimuth==sec_lo OR azimuth==sec_hi).
- Sector mode with latched sec_lo>=sec_hi behaves exactly as continuous mode.
- Trigger:
  - trig=1 while tphase<TRIG_WIDTH, in RUN or STOP.
  - tphase free-runs independently of phase.
  - Entering IDLE forces trig=0 immediately, even mid-pulse.
- Asynchronous reset at any time forces all outputs and state to reset values on the reset assertion edge.

## Timing
- Latency: en sampled high in IDLE at edge N gives acp=1, trig=1, running=1 and the start azimuth valid after edge N.
- ACP period is exactly ACP_PERIOD cycles, with ACP_HIGH high cycles followed by ACP_PERIOD-ACP_HIGH low cycles.
- azimuth changes only on the edge where acp rises.
- arp rises and falls on the same edges as acp, and only on qualifying pulses.
- Continuous revolution is 2^AZ_BITS × ACP_PERIOD cycles.
- TRIG period is exactly TRIG_PERIOD cycles, with its first pulse starting on the RUN entry edge.
- Stop: with en low at phase p, running falls ACP_PERIOD-p cycles later. acp is never high in IDLE.

## Test plan
All scenarios use sim parameters AZ_BITS=3, ACP_PERIOD=8, ACP_HIGH=3, TRIG_PERIOD=10, TRIG_WIDTH=2.

- Reset: rst=0 with random inputs → all outputs 0; rst=1 with en=0 → outputs stay 0 and running=0.
- Continuous run: en=1, mode=0 → acp high 3 / low 5 cycles; azimuth sequence 0,1,…,7,0; arp high only during the azimuth-0 pulse (once per 64 cycles); trig high 2 of every 10 cycles.
- Sector scan: mode=1, sec_lo=2, sec_hi=5 → azimuth sequence 2,3,4,5,4,3,2,3…; dir falls with azimuth=4 and rises with azimuth=3; arp asserted on the azimuth-2 and azimuth-5 pulses only.
- Stop mid-period: en→0 at phase 1 → acp completes its 3 high cycles, running falls 7 cycles later, trig forced 0 at IDLE entry; en re-asserted during STOP → no phase reset and no gap.
- Mid-run change and degenerate sector: change mode/sec_* during RUN → no effect; restart with sec_lo=6, sec_hi=6 → continuous sequence 0..7 wrapping.
- Asynchronous reset: rst pulled low mid-ACP high phase → acp, arp, trig, azimuth, dir and running all 0 without waiting for a clk edge; the next run starts at azimuth 0.
